// File: rtl/cnt163_pkg.sv
// ============================================================================
//  cnt163_pkg : command op-codes and controller FSM states for cnt163_ctrl
//  Revision   : 1.0
// ============================================================================
`default_nettype none

package cnt163_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_RUN   = 2'b10,
        OP_STOP  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cnt163_core.sv
// ============================================================================
//  cnt163_core : 74x163-style counter register with clear/load/increment
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cnt163_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic             ent,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Clear beats load beats increment; increment wraps naturally.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = load_data;
        end else if (inc) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign rco = ent && (q_q == '1);

endmodule

`default_nettype wire

// File: rtl/cnt163_ctrl.sv
// ============================================================================
//  cnt163_ctrl : command-driven run-length controller around cnt163_core
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cnt163_ctrl
    import cnt163_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             enp,
    input  logic             ent,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    state_e           state_d;
    logic [LEN_W-1:0] remaining_q;
    logic [LEN_W-1:0] remaining_d;
    logic             accept;
    logic             core_clr;
    logic             core_load;
    logic             core_inc;

    assign cmd_ready = rst_n && (state_q != ST_DONE);
    assign accept    = cmd_valid && cmd_ready;

    // An accepted command always wins over an increment on the same edge.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        core_clr    = 1'b0;
        core_load   = 1'b0;
        core_inc    = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    case (op_e'(cmd_op))
                        OP_CLEAR: begin
                            core_clr    = 1'b1;
                            state_d     = ST_IDLE;
                            remaining_d = '0;
                        end
                        OP_LOAD: begin
                            core_load   = 1'b1;
                            state_d     = ST_IDLE;
                            remaining_d = '0;
                        end
                        OP_RUN: begin
                            state_d     = ST_RUN;
                            remaining_d = cmd_len;
                        end
                        default: begin
                            state_d     = ST_IDLE;
                            remaining_d = '0;
                        end
                    endcase
                end else if (state_q == ST_RUN) begin
                    // A zero-length run finishes without ever touching q.
                    if (remaining_q == '0) begin
                        state_d = ST_DONE;
                    end else if (enp && ent) begin
                        core_inc    = 1'b1;
                        remaining_d = remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    cnt163_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (core_clr),
        .load     (core_load),
        .inc      (core_inc),
        .ent      (ent),
        .load_data(cmd_data),
        .q        (q),
        .rco      (rco)
    );

endmodule

`default_nettype wire
